// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/load/link data, extracts sub-word loads and holds loads until memory returns.
// Optional misaligned-load trap enabled by defining WB_TRAP_MISALIGNED_EN.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   write_data,
    output logic              reg_write,
    output logic              busy_valid,
    output logic [REG_AW-1:0] busy_rd,
    output logic              misalign_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic              ld_we_r;
    logic [2:0]        ld_funct3_r;
    logic [1:0]        ld_off_r;
    logic [XLEN-1:0]   alu_data_s;
    logic [XLEN-1:0]   load_data_s;
    logic              ld_misaligned_s;

    // Sub-word extraction; halfwords use only offset bit 1, so offsets are naturally masked.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

`ifdef WB_TRAP_MISALIGNED_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b001, 3'b101: is_misaligned = off[0];
            3'b010:         is_misaligned = (off != 2'b00);
            default:        is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    assign in_ready = (state_r == ST_IDLE);

    // Non-load source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        alu_data_s = in_alu_result;
        if (in_wb_sel == 2'b10) begin
            alu_data_s = in_pc_plus4;
        end else begin
            alu_data_s = in_alu_result;
        end
    end

    // Load result and misalignment decode for the pending load.
    always_comb begin
        load_data_s = load_extract(ld_funct3_r, ld_off_r, mem_rdata);
`ifdef WB_TRAP_MISALIGNED_EN
        ld_misaligned_s = is_misaligned(ld_funct3_r, ld_off_r);
`else
        ld_misaligned_s = 1'b0;
`endif
    end

    // Stage state machine and registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rd           <= {REG_AW{1'b0}};
            write_data   <= {XLEN{1'b0}};
            reg_write    <= 1'b0;
            busy_valid   <= 1'b0;
            busy_rd      <= {REG_AW{1'b0}};
            misalign_err <= 1'b0;
            ld_we_r      <= 1'b0;
            ld_funct3_r  <= 3'b000;
            ld_off_r     <= 2'b00;
        end else begin
            reg_write    <= 1'b0;
            misalign_err <= 1'b0;
            if (flush) begin
                state_r    <= ST_IDLE;
                busy_valid <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_valid) begin
                            if (in_wb_sel == 2'b01) begin
                                state_r     <= ST_WAIT;
                                busy_valid  <= 1'b1;
                                busy_rd     <= in_rd;
                                ld_we_r     <= in_reg_write;
                                ld_funct3_r <= in_funct3;
                                ld_off_r    <= in_addr_lo;
                            end else if (in_reg_write && (in_rd != {REG_AW{1'b0}})) begin
                                reg_write  <= 1'b1;
                                rd         <= in_rd;
                                write_data <= alu_data_s;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (mem_rvalid) begin
                            state_r    <= ST_IDLE;
                            busy_valid <= 1'b0;
                            if (ld_misaligned_s) begin
                                misalign_err <= 1'b1;
                            end else if (ld_we_r && (busy_rd != {REG_AW{1'b0}})) begin
                                reg_write  <= 1'b1;
                                rd         <= busy_rd;
                                write_data <= load_data_s;
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        busy_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result, in_pc_plus4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        reg_write, busy_valid;
    logic [4:0]  busy_rd;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    writeback_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rd(rd), .write_data(write_data),
        .reg_write(reg_write), .busy_valid(busy_valid), .busy_rd(busy_rd), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] r, input logic we,
                         input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] pc4);
        in_valid = v; in_wb_sel = sel; in_rd = r; in_reg_write = we;
        in_funct3 = f3; in_addr_lo = off; in_alu_result = alu; in_pc_plus4 = pc4;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        drive(1'b1, 2'b00, 5'd5, 1'b1, 3'b000, 2'b00, 32'h11111111, 32'h0);
        tick(); tick();
        check("rst_reg_write", {31'b0, reg_write}, 32'd0);
        check("rst_busy_valid", {31'b0, busy_valid}, 32'd0);
        check("rst_write_data", write_data, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_rd", {27'b0, rd}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);

        // Back-to-back ALU ops
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 5'd5, 1'b1, 3'b000, 2'b00, 32'h12345678, 32'h0);
        tick();
        check("alu1_we", {31'b0, reg_write}, 32'd1);
        check("alu1_rd", {27'b0, rd}, 32'd5);
        check("alu1_data", write_data, 32'h12345678);
        drive(1'b1, 2'b00, 5'd6, 1'b1, 3'b000, 2'b00, 32'hFFFF0000, 32'h0);
        tick();
        check("alu2_we", {31'b0, reg_write}, 32'd1);
        check("alu2_rd", {27'b0, rd}, 32'd6);
        check("alu2_data", write_data, 32'hFFFF0000);
        in_valid = 1'b0;
        tick();
        check("idle_we", {31'b0, reg_write}, 32'd0);
        check("idle_hold_data", write_data, 32'hFFFF0000);

        // JAL link value, then x0 destination
        drive(1'b1, 2'b10, 5'd1, 1'b1, 3'b000, 2'b00, 32'hAAAAAAAA, 32'h00000104);
        tick();
        check("jal_we", {31'b0, reg_write}, 32'd1);
        check("jal_data", write_data, 32'h00000104);
        drive(1'b1, 2'b10, 5'd0, 1'b1, 3'b000, 2'b00, 32'hAAAAAAAA, 32'h00000208);
        tick();
        check("x0_we", {31'b0, reg_write}, 32'd0);
        check("x0_hold_rd", {27'b0, rd}, 32'd1);
        check("x0_hold_data", write_data, 32'h00000104);

        // Reserved select behaves as ALU; disabled write is suppressed
        drive(1'b1, 2'b11, 5'd13, 1'b1, 3'b000, 2'b00, 32'h0BADF00D, 32'h00000200);
        tick();
        check("sel11_data", write_data, 32'h0BADF00D);
        drive(1'b1, 2'b00, 5'd14, 1'b0, 3'b000, 2'b00, 32'h00000077, 32'h0);
        tick();
        check("nowe_we", {31'b0, reg_write}, 32'd0);
        check("nowe_hold", write_data, 32'h0BADF00D);

        // LB o=3 with 3-cycle memory latency
        drive(1'b1, 2'b01, 5'd7, 1'b1, 3'b000, 2'b11, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lb_busy", {31'b0, busy_valid}, 32'd1);
            check("lb_ready", {31'b0, in_ready}, 32'd0);
            check("lb_we", {31'b0, reg_write}, 32'd0);
            if (i < 2) tick();
        end
        check("lb_busy_rd", {27'b0, busy_rd}, 32'd7);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
        tick();
        check("lb_done_we", {31'b0, reg_write}, 32'd1);
        check("lb_done_rd", {27'b0, rd}, 32'd7);
        check("lb_done_data", write_data, 32'hFFFFFF80);
        check("lb_done_busy", {31'b0, busy_valid}, 32'd0);
        tick();
        check("rvalid_idle_ignored", {31'b0, reg_write}, 32'd0);
        mem_rvalid = 1'b0;

        // LHU o=2
        drive(1'b1, 2'b01, 5'd8, 1'b1, 3'b101, 2'b10, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("lhu_busy", {31'b0, busy_valid}, 32'd1);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("lhu_we", {31'b0, reg_write}, 32'd1);
        check("lhu_data", write_data, 32'h000080FF);

        // LH o=2 sign extension
        drive(1'b1, 2'b01, 5'd15, 1'b1, 3'b001, 2'b10, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("lh_data", write_data, 32'hFFFF80FF);

        // Flush in WAIT beats a simultaneous mem_rvalid
        drive(1'b1, 2'b01, 5'd9, 1'b1, 3'b010, 2'b00, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        check("fl_busy", {31'b0, busy_valid}, 32'd1);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12121212;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        check("fl_we", {31'b0, reg_write}, 32'd0);
        check("fl_busy_clr", {31'b0, busy_valid}, 32'd0);
        check("fl_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 2'b00, 5'd10, 1'b1, 3'b000, 2'b00, 32'h55AA55AA, 32'h0);
        tick();
        check("post_fl_we", {31'b0, reg_write}, 32'd1);
        check("post_fl_data", write_data, 32'h55AA55AA);

        // Flush discards a same-cycle accept
        drive(1'b1, 2'b00, 5'd11, 1'b1, 3'b000, 2'b00, 32'h99999999, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_acc_we", {31'b0, reg_write}, 32'd0);
        check("fl_acc_rd", {27'b0, rd}, 32'd10);

        // Misaligned LW o=1
        drive(1'b1, 2'b01, 5'd12, 1'b1, 3'b010, 2'b01, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
`ifdef WB_TRAP_MISALIGNED_EN
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        check("mis_we", {31'b0, reg_write}, 32'd0);
        check("mis_data_hold", write_data, 32'h55AA55AA);
`else
        check("mis_err", {31'b0, misalign_err}, 32'd0);
        check("mis_we", {31'b0, reg_write}, 32'd1);
        check("mis_data", write_data, 32'hDEADBEEF);
`endif
        tick();
        check("mis_err_pulse", {31'b0, misalign_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Takes retired instructions from the memory stage and produces the register-file write port: rd, write_data, reg_write.
- Selects the writeback source (ALU result, load data, or PC+4) and extracts and extends sub-word loads.
- Holds load instructions until the synchronous data memory returns read data.
- Exposes a busy indication so the hazard logic can stall dependent instructions.

Parameters:
XLEN, 32, datapath and register width
REG_AW, 5, register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous kill of pending and incoming work
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept
in_rd  input  REG_AW  destination register
in_reg_write  input  1  instruction writes a register
in_wb_sel  input  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved
in_funct3  input  3  load type
in_addr_lo  input  2  load address bits [1:0]
in_alu_result  input  XLEN  ALU result
in_pc_plus4  input  XLEN  link value
mem_rvalid  input  1  memory read data valid
mem_rdata  input  XLEN  raw aligned memory word
rd  output  REG_AW  register-file write index
write_data  output  XLEN  register-file write data
reg_write  output  1  register-file write enable, one-cycle pulse
busy_valid  output  1  load pending in WAIT
busy_rd  output  REG_AW  rd of the pending load
misalign_err  output  1  one-cycle misaligned-load pulse (optional feature)

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - rd, write_data, reg_write, busy_valid, busy_rd and misalign_err all go to 0.
- States: IDLE and WAIT.
- in_ready is 1 in IDLE and 0 in WAIT. It is combinational from the state only.
- Accept means in_valid && in_ready at a clock edge.
- Non-load accepted at edge N (in_wb_sel != 01):
  - reg_write pulses high in cycle N+1 with registered rd and write_data.
  - The state stays IDLE, so back-to-back accepts give back-to-back pulses.
- Load accepted at edge N (in_wb_sel == 01):
  - Captures in_rd, in_reg_write, in_funct3 and in_addr_lo, then goes to WAIT.
  - busy_valid is 1 and busy_rd holds the captured rd while in WAIT.
- In WAIT, mem_rvalid sampled high at edge M:
  - The stage extracts data and returns to IDLE.
  - reg_write pulses in cycle M+1.
  - busy_valid drops in cycle M+1.
- mem_rvalid is ignored in IDLE. It is never sampled in the same cycle the load is accepted.
- Load extraction with byte offset o = in_addr_lo:
  - 000 LB: sign-extend byte o.
  - 100 LBU: zero-extend byte o.
  - 001 LH: sign-extend halfword o[1].
  - 101 LHU: zero-extend halfword o[1].
  - 010 LW and all other encodings: the full word.
- Source select: wb_sel 11 is treated as 00 (ALU).
- x0 and disabled writes: reg_write is never asserted when rd == 0 or in_reg_write == 0. The instruction still flows through the stage normally.
- write_data and rd hold their last value when reg_write is 0.
- Flush:
  - flush high at an edge forces IDLE and clears busy_valid.
  - It suppresses any reg_write for the next cycle and discards a same-cycle accept.
  - flush beats a simultaneous mem_rvalid.
- Reset beats flush and all other inputs.

Optional Feature:
Macro WB_TRAP_MISALIGNED_EN.
- Defined:
  - A misaligned load is LH/LHU with o[0]=1, or LW with o != 0.
  - It still waits for mem_rvalid.
  - On completion it pulses misalign_err in cycle M+1 instead of reg_write; rd and write_data are unchanged.
- Not defined:
  - misalign_err is tied to 0.
  - Offsets are masked to natural alignment: halfword uses o[1] only, word ignores o.
  - The write proceeds normally.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> reg_write=0, busy_valid=0, write_data=0, in_ready=1.
- ALU ops: back-to-back wb_sel=00 ops rd=5 alu=0x12345678, then rd=6 alu=0xFFFF0000 -> reg_write high for 2 consecutive cycles with matching rd/data.
- JAL and x0:
  - wb_sel=10, rd=1, pc_plus4=0x104 -> write_data=0x104.
  - Same with rd=0 -> no reg_write.
- LB with 3-cycle memory latency:
  - funct3=000, o=3, mem_rdata=0x80FF7F01 arriving 3 cycles after accept -> busy_valid and in_ready=0 for 3 cycles, then write_data=0xFFFFFF80.
  - Repeat with LHU, o=2 -> 0x000080FF.
- Flush mid-load: flush while in WAIT, with mem_rvalid in the same cycle -> no reg_write; IDLE next cycle; a new ALU op is accepted and written.
- Misaligned LW with o=1 and mem_rdata=0xDEADBEEF:
  - With the macro: misalign_err pulse, no reg_write.
  - Without the macro: write_data=0xDEADBEEF.
